// File: rtl/netcfg_pkg.sv
// Shared types and constants for the EEPROM network-configuration loader.
package netcfg_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        WAIT     = 3'd2,
        CHECK    = 3'd3,
        LOAD_DEF = 3'd4,
        STREAM   = 3'd5,
        WAIT_FIN = 3'd6
    } state_e;

    localparam int IMG_LEN  = 21;
    localparam int CFG_LEN  = 18;
    localparam int CFG_OFS  = 2;
    localparam int CSUM_OFS = 20;

    localparam logic [1:0] FAIL_NONE  = 2'd0;
    localparam logic [1:0] FAIL_MAGIC = 2'd1;
    localparam logic [1:0] FAIL_CSUM  = 2'd2;
    localparam logic [1:0] FAIL_READ  = 2'd3;

    // Byte i of a big-endian packed config vector (byte 0 = MAC[47:40]).
    function automatic logic [7:0] cfg_byte(input logic [8*CFG_LEN-1:0] cfg, input int i);
        return cfg[8*(CFG_LEN-1-i) +: 8];
    endfunction

endpackage

// File: rtl/eeprom_netcfg_loader.sv
// Reads a 21-byte config image from EEPROM, validates magic and checksum,
// and streams the 18 config bytes (or defaults) to the network helper over AXIS.
module eeprom_netcfg_loader
    import netcfg_pkg::*;
#(
    parameter logic [7:0]  BASE_ADDR      = 8'h00,
    parameter logic [15:0] MAGIC          = 16'hC0DE,
    parameter logic [47:0] DEFAULT_MAC    = 48'h02_00_00_00_00_01,
    parameter logic [31:0] DEFAULT_IP     = 32'hC0A8_0180,
    parameter logic [31:0] DEFAULT_GW     = 32'hC0A8_0101,
    parameter logic [31:0] DEFAULT_MASK   = 32'hFFFF_FF00,
    parameter int          RETRY_MAX      = 3,
    parameter int          TIMEOUT_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       used_eeprom,
    output logic [1:0] fail_code,
    output logic       rd_req_valid,
    input  logic       rd_req_ready,
    output logic [7:0] rd_req_addr,
    input  logic       rd_rsp_valid,
    input  logic [7:0] rd_rsp_data,
    input  logic       rd_rsp_err,
    output logic       m_proc_start,
    input  logic       m_proc_finished,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready
);

    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [8*CFG_LEN-1:0] DEFAULT_CFG = {DEFAULT_MAC, DEFAULT_IP, DEFAULT_GW, DEFAULT_MASK};

    state_e        state_q;
    logic [4:0]    idx_q;
    logic [4:0]    out_idx_q;
    logic [RW-1:0] retry_q;
    logic [TW-1:0] tmo_q;
    logic [7:0]    sum_q;
    logic [7:0]    img_q [IMG_LEN];
    logic          fin_seen_q;
    logic          busy_q;
    logic          done_q;
    logic          used_q;
    logic [1:0]    fail_q;
    logic          req_valid_q;
    logic [7:0]    req_addr_q;
    logic          proc_start_q;
    logic [7:0]    tdata_q;
    logic          tvalid_q;

    logic [4:0]    idx_inc_d;
    logic [4:0]    out_ofs_d;
    logic          retry_ev_d;

    assign idx_inc_d = idx_q + 5'd1;
    // Buffer offset of the byte following the one currently presented.
    assign out_ofs_d = out_idx_q + 5'(CFG_OFS + 1);
    // A failed attempt: error response, or the wait expired with no response at all.
    assign retry_ev_d = rd_rsp_valid ? rd_rsp_err : (tmo_q == TMO_LAST);

    assign busy          = busy_q;
    assign done          = done_q;
    assign used_eeprom   = used_q;
    assign fail_code     = fail_q;
    assign rd_req_valid  = req_valid_q;
    assign rd_req_addr   = req_addr_q;
    assign m_proc_start  = proc_start_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;

    // Load sequencer: EEPROM read loop, image validation, AXIS stream and helper handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= 5'd0;
            out_idx_q    <= 5'd0;
            retry_q      <= '0;
            tmo_q        <= '0;
            sum_q        <= 8'h00;
            for (int i = 0; i < IMG_LEN; i++) img_q[i] <= 8'h00;
            fin_seen_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            used_q       <= 1'b0;
            fail_q       <= FAIL_NONE;
            req_valid_q  <= 1'b0;
            req_addr_q   <= 8'h00;
            proc_start_q <= 1'b0;
            tdata_q      <= 8'h00;
            tvalid_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q       <= 5'd0;
                        retry_q     <= '0;
                        sum_q       <= 8'h00;
                        fail_q      <= FAIL_NONE;
                        used_q      <= 1'b0;
                        fin_seen_q  <= 1'b0;
                        busy_q      <= 1'b1;
                        req_valid_q <= 1'b1;
                        req_addr_q  <= BASE_ADDR;
                        state_q     <= REQ;
                    end
                end
                REQ: begin
                    if (rd_req_ready) begin
                        req_valid_q <= 1'b0;
                        tmo_q       <= '0;
                        state_q     <= WAIT;
                    end
                end
                WAIT: begin
                    if (rd_rsp_valid && !rd_rsp_err) begin
                        img_q[idx_q] <= rd_rsp_data;
                        sum_q        <= sum_q + rd_rsp_data;
                        if (idx_q == 5'(CSUM_OFS)) begin
                            state_q <= CHECK;
                        end else begin
                            idx_q       <= idx_inc_d;
                            retry_q     <= '0;
                            req_addr_q  <= BASE_ADDR + {3'b000, idx_inc_d};
                            req_valid_q <= 1'b1;
                            state_q     <= REQ;
                        end
                    end else if (retry_ev_d) begin
                        if (retry_q < RETRY_LIM) begin
                            retry_q     <= retry_q + RW'(1);
                            req_valid_q <= 1'b1;
                            state_q     <= REQ;
                        end else begin
                            fail_q  <= FAIL_READ;
                            state_q <= LOAD_DEF;
                        end
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                CHECK: begin
                    if ({img_q[0], img_q[1]} != MAGIC) begin
                        fail_q  <= FAIL_MAGIC;
                        state_q <= LOAD_DEF;
                    end else if (sum_q != 8'h00) begin
                        fail_q  <= FAIL_CSUM;
                        state_q <= LOAD_DEF;
                    end else begin
                        used_q       <= 1'b1;
                        out_idx_q    <= 5'd0;
                        tdata_q      <= img_q[CFG_OFS];
                        tvalid_q     <= 1'b1;
                        proc_start_q <= 1'b1;
                        state_q      <= STREAM;
                    end
                end
                LOAD_DEF: begin
                    for (int i = 0; i < CFG_LEN; i++) img_q[CFG_OFS + i] <= cfg_byte(DEFAULT_CFG, i);
                    used_q       <= 1'b0;
                    out_idx_q    <= 5'd0;
                    tdata_q      <= cfg_byte(DEFAULT_CFG, 0);
                    tvalid_q     <= 1'b1;
                    proc_start_q <= 1'b1;
                    state_q      <= STREAM;
                end
                STREAM: begin
                    if (m_axis_tready) begin
                        if (out_idx_q == 5'(CFG_LEN - 1)) begin
                            tvalid_q <= 1'b0;
                            state_q  <= WAIT_FIN;
                        end else begin
                            out_idx_q <= out_idx_q + 5'd1;
                            tdata_q   <= img_q[out_ofs_d];
                        end
                    end
                end
                WAIT_FIN: begin
                    if (!fin_seen_q) begin
                        if (m_proc_finished) begin
                            proc_start_q <= 1'b0;
                            fin_seen_q   <= 1'b1;
                        end
                    end else if (!m_proc_finished) begin
                        fin_seen_q <= 1'b0;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/eeprom_netcfg_loader.md
Name: eeprom_netcfg_loader

Overview:
- Upstream feeder for the network-parameter helper.
- On `start`, reads a 21-byte configuration image from the board EEPROM through the shared byte-read request/response port of the I2C master.
- Validates the image's magic word and checksum, then streams 18 bytes (MAC, IP, gateway, mask; big-endian) over AXIS under the helper's process_start/process_finished handshake.
- On an invalid image or a read failure, streams the parameter defaults instead.

Parameters:
- BASE_ADDR, 8'h00, EEPROM word address of image byte 0
- MAGIC, 16'hC0DE, required value of image bytes 0..1
- DEFAULT_MAC, 48'h02_00_00_00_00_01, fallback MAC
- DEFAULT_IP, 32'hC0A8_0180, fallback IP (192.168.1.128)
- DEFAULT_GW, 32'hC0A8_0101, fallback gateway
- DEFAULT_MASK, 32'hFFFF_FF00, fallback subnet mask
- RETRY_MAX, 3, reads re-issued per byte after error/timeout
- TIMEOUT_CYCLES, 1000, cycles to wait for rd_rsp_valid

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- start  in  1  pulse; begin load
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at completion
- used_eeprom  out  1  1 = EEPROM image streamed, 0 = defaults; valid from done until next start
- fail_code  out  2  0 ok, 1 bad magic, 2 bad checksum, 3 read failure
- rd_req_valid  out  1  byte-read request
- rd_req_ready  in  1  request accepted
- rd_req_addr  out  8  BASE_ADDR + index
- rd_rsp_valid  in  1  response strobe
- rd_rsp_data  in  8  read byte
- rd_rsp_err  in  1  NACK/bus error on this response
- m_proc_start  out  1  to helper s_eeprom_process_start
- m_proc_finished  in  1  from helper s_eeprom_process_finished
- m_axis_tdata  out  8  config byte
- m_axis_tvalid  out  1  AXIS valid
- m_axis_tready  in  1  AXIS ready

Behaviour:

Reset:
- Every output resets to 0; state resets to IDLE.
- rst_n low mid-operation aborts immediately; no partial stream is resumed.

Image layout (offsets from BASE_ADDR):
- Bytes 0..1: magic, MSB first.
- Bytes 2..19: config — MAC[47:40] first, then IP, GW, mask.
- Byte 20: checksum.
- Valid image: mod-256 sum of bytes 0..20 == 8'h00.

States:
- IDLE: start → clear index, retry count, sum and fail_code; busy <= 1; go to REQ. start while busy is ignored.
- REQ: rd_req_valid = 1, rd_req_addr = BASE_ADDR + idx (8-bit wrap).
  - On rd_req_valid & rd_req_ready: drop rd_req_valid, clear timeout counter, go to WAIT.
- WAIT: rd_rsp_valid outside WAIT is ignored. On rd_rsp_valid:
  - rd_rsp_err = 0:
    - Store the byte into the 21-byte buffer and add it to sum.
    - idx == 20 → go to CHECK; otherwise idx++, retries = 0, go to REQ.
  - rd_rsp_err = 1, or counter reaches TIMEOUT_CYCLES:
    - retries < RETRY_MAX → retries++, go to REQ (same idx).
    - Otherwise fail_code = 3, go to LOAD_DEF.
  - rd_rsp_valid and timeout in the same cycle: the response wins.
- CHECK (1 cycle):
  - Magic mismatch → fail_code = 1, go to LOAD_DEF.
  - Else sum != 0 → fail_code = 2, go to LOAD_DEF.
  - Else used_eeprom = 1, go to STREAM.
- LOAD_DEF (1 cycle): overwrite buffer bytes 2..19 from the DEFAULT_* parameters; used_eeprom = 0; go to STREAM.
- STREAM:
  - m_proc_start = 1, m_axis_tvalid = 1, m_axis_tdata = buf[2 + out_idx].
  - Advance out_idx only on tvalid & tready; tdata and tvalid stay stable while tready is low.
  - After transfer of out_idx == 17: tvalid <= 0, go to WAIT_FIN.
- WAIT_FIN:
  - Hold m_proc_start until m_proc_finished == 1, then drop m_proc_start.
  - Wait for m_proc_finished == 0, then pulse done for 1 cycle, busy <= 0, go to IDLE.
- m_proc_finished rising before all 18 bytes are sent is ignored until WAIT_FIN.
- Latency from start to first rd_req_valid: 1 cycle. From last response to first tvalid: 2 cycles (EEPROM image) or 3 cycles (defaults).

Decomposition:
- Package netcfg_pkg:
  - state enum: IDLE, REQ, WAIT, CHECK, LOAD_DEF, STREAM, WAIT_FIN
  - IMG_LEN = 21, CFG_LEN = 18, CFG_OFS = 2, CSUM_OFS = 20
  - fail_code localparams: FAIL_NONE, FAIL_MAGIC, FAIL_CSUM, FAIL_READ
- Single module; no sub-module. The 21-byte buffer and sum accumulator are inline.

Test Plan:
- Valid image C0 DE 02 11 22 33 44 55 C0 A8 00 0A C0 A8 00 01 FF FF FF 00 + checksum byte, tready always 1 → 18 bytes streamed in order; used_eeprom = 1; fail_code = 0; done pulses once.
- Magic 0xBEEF → defaults streamed (02 00 00 00 00 01 C0 A8 01 80 …); fail_code = 1.
- Correct magic, checksum off by 1 → defaults streamed; fail_code = 2.
- rd_rsp_err on byte 7 twice, then OK → same address re-requested twice; image accepted.
- No response to byte 3 → 4 requests spaced by TIMEOUT_CYCLES, then defaults streamed; fail_code = 3.
- tready toggling 1010… plus rst_n low at the 5th transfer → outputs 0 asynchronously; a fresh start re-runs cleanly.
